// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: frames a byte onto tx_serial using a fractional baud accumulator.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frame instead of 10-bit).
module uart_tx_sequencer #(
    parameter logic [31:0] CLK_FREQ_HZ = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_en,
    input  logic        load,
    input  logic [7:0]  tx_data,
    input  logic [31:0] baud_rate,
    output logic        tx_serial,
    output logic        busy,
    output logic        data_transmitted
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
`ifdef UART_TX_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    state_t      state_q;
    logic [32:0] acc_q;
    logic [32:0] acc_d;
    logic [32:0] acc_sum;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic        tx_serial_q;
    logic        busy_q;
    logic        data_transmitted_q;
    logic        fast_baud;
    logic        tick;
`ifdef UART_TX_PARITY_EN
    logic        parity_q;
`endif

    // Phase accumulator: acc stays below CLK_FREQ_HZ, so acc+baud fits in 33 bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        acc_sum   = acc_q + {1'b0, baud_rate};
        fast_baud = (baud_rate >= CLK_FREQ_HZ);
        tick      = 1'b0;
        acc_d     = acc_sum;
        if (fast_baud) begin
            tick  = 1'b1;
            acc_d = '0;
        end else if (acc_sum >= {1'b0, CLK_FREQ_HZ}) begin
            tick  = 1'b1;
            acc_d = acc_sum - {1'b0, CLK_FREQ_HZ};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= ST_IDLE;
            acc_q              <= '0;
            shift_q            <= '0;
            bit_cnt_q          <= '0;
            tx_serial_q        <= 1'b1;
            busy_q             <= 1'b0;
            data_transmitted_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q           <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_serial_q        <= 1'b1;
                    busy_q             <= 1'b0;
                    data_transmitted_q <= 1'b0;
                    if (tx_en && load && (baud_rate != '0)) begin
                        shift_q     <= tx_data;
                        acc_q       <= '0;
                        bit_cnt_q   <= '0;
                        state_q     <= ST_START;
                        tx_serial_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q    <= ^tx_data;
`endif
                    end
                end
                ST_START: begin
                    acc_q <= acc_d;
                    if (tick) begin
                        state_q     <= ST_DATA;
                        bit_cnt_q   <= '0;
                        tx_serial_q <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    acc_q <= acc_d;
                    if (tick) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q     <= ST_PARITY;
                            tx_serial_q <= parity_q;
`else
                            state_q     <= ST_STOP;
                            tx_serial_q <= 1'b1;
`endif
                        end else begin
                            tx_serial_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    acc_q <= acc_d;
                    if (tick) begin
                        state_q     <= ST_STOP;
                        tx_serial_q <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    acc_q <= acc_d;
                    if (tick) begin
                        state_q            <= ST_DONE;
                        data_transmitted_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    acc_q              <= acc_d;
                    state_q            <= ST_IDLE;
                    data_transmitted_q <= 1'b0;
                    busy_q             <= 1'b0;
                    tx_serial_q        <= 1'b1;
                end
                default: begin
                    state_q            <= ST_IDLE;
                    tx_serial_q        <= 1'b1;
                    busy_q             <= 1'b0;
                    data_transmitted_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_serial        = tx_serial_q;
    assign busy             = busy_q;
    assign data_transmitted = data_transmitted_q;

endmodule
